// File: rtl/crono_countdown.sv
// Chronometer countdown engine: latches a BCD HH:MM:SS preset and counts it
// down to 00:00:00 on 1 Hz ticks, raising a sticky done flag on expiry.

module crono_bcd_dec #(
    parameter logic [3:0] TOP = 4'd9
) (
    input  logic [3:0] digit_in,
    input  logic       borrow_in,
    output logic [3:0] digit_out,
    output logic       borrow_out
);
    always_comb begin
        digit_out  = digit_in;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit_in == 4'd0) begin
                digit_out  = TOP;
                borrow_out = 1'b1;
            end else begin
                digit_out = digit_in - 4'd1;
            end
        end
    end
endmodule

module crono_countdown (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic       alarm_clr,
    input  logic [7:0] HCcr,
    input  logic [7:0] MCcr,
    input  logic [7:0] SCcr,
    output logic [7:0] HCact,
    output logic [7:0] MCact,
    output logic [7:0] SCact,
    output logic       running,
    output logic       done,
    output logic       load_err
);
    localparam int NUM_DIGITS = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        running_q;
    logic        load_err_q, load_err_d;

    logic [23:0] preset;
    logic [23:0] dec_val;
    logic [NUM_DIGITS:0] borrow;
    logic        preset_ok;
    logic        cnt_zero;
    logic        dec_zero;

    assign preset = {HCcr, MCcr, SCcr};

    always_comb begin
        preset_ok = (HCcr[3:0] <= 4'd9) && (HCcr[7:4] <= 4'd9) &&
                    (MCcr[3:0] <= 4'd9) && (MCcr[7:4] <= 4'd5) &&
                    (SCcr[3:0] <= 4'd9) && (SCcr[7:4] <= 4'd5) &&
                    (HCcr <= 8'h23);
    end

    // One-second BCD decrement as a ripple-borrow chain, seconds units first.
    // Units wrap to 9, minute/second tens wrap to 5.
    assign borrow[0] = 1'b1;
    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            localparam logic [3:0] TOP = (i % 2 == 0) ? 4'd9 :
                                         (i == NUM_DIGITS - 1) ? 4'd2 : 4'd5;
            crono_bcd_dec #(.TOP(TOP)) u_dec (
                .digit_in   (cnt_q[4*i +: 4]),
                .borrow_in  (borrow[i]),
                .digit_out  (dec_val[4*i +: 4]),
                .borrow_out (borrow[i+1])
            );
        end
    endgenerate

    // A borrow escaping the hours tens digit means every digit was zero.
    assign cnt_zero = borrow[NUM_DIGITS];
    assign dec_zero = (dec_val == 24'h0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 24'h0;
            done_q     <= 1'b0;
            running_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            running_q  <= (state_d == RUN);
            load_err_q <= load_err_d;
        end
    end

    // load always takes precedence over start, even when the preset is rejected.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!load && start && !cnt_zero)
                    state_d = RUN;
            end
            RUN: begin
                if (tick && dec_zero)
                    state_d = DONE;
                else if (stop)
                    state_d = PAUSE;
            end
            PAUSE: begin
                if (load) begin
                    if (preset_ok)
                        state_d = IDLE;
                end else if (start && !cnt_zero) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if ((load && preset_ok) || alarm_clr)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        done_d     = done_q;
        load_err_d = 1'b0;
        case (state_q)
            IDLE, PAUSE: begin
                if (load) begin
                    if (preset_ok)
                        cnt_d = preset;
                    else
                        load_err_d = 1'b1;
                end
            end
            RUN: begin
                if (tick) begin
                    cnt_d = dec_val;
                    if (dec_zero)
                        done_d = 1'b1;
                end
            end
            DONE: begin
                if (load) begin
                    if (preset_ok) begin
                        cnt_d  = preset;
                        done_d = 1'b0;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
                if (alarm_clr)
                    done_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign HCact    = cnt_q[23:16];
    assign MCact    = cnt_q[15:8];
    assign SCact    = cnt_q[7:0];
    assign running  = running_q;
    assign done     = done_q;
    assign load_err = load_err_q;
endmodule

// File: tb/tb_crono_countdown.sv
// Directed bench for crono_countdown: the driver queues hand-computed expected
// outputs per cycle and an independent monitor pops and compares them.

module tb_crono_countdown;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, alarm_clr = 1'b0;
    logic [7:0] HCcr = 8'h00, MCcr = 8'h00, SCcr = 8'h00;
    logic [7:0] HCact, MCact, SCact;
    logic       running, done, load_err;

    typedef struct packed {
        logic [7:0] h, m, s;
        logic       r, d, e;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_chk = 0;
    int    n_fail = 0;

    crono_countdown dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load), .start(start),
        .stop(stop), .alarm_clr(alarm_clr), .HCcr(HCcr), .MCcr(MCcr), .SCcr(SCcr),
        .HCact(HCact), .MCact(MCact), .SCact(SCact),
        .running(running), .done(done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Monitor: outputs settle after posedge; everything queued is checked at negedge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_chk++;
            if ({HCact, MCact, SCact, running, done, load_err} !== {e.h, e.m, e.s, e.r, e.d, e.e}) begin
                n_fail++;
                $display("FAIL %s: got %h:%h:%h run=%b done=%b err=%b, want %h:%h:%h run=%b done=%b err=%b",
                         nm, HCact, MCact, SCact, running, done, load_err,
                         e.h, e.m, e.s, e.r, e.d, e.e);
            end
        end
    end

    task automatic step(input logic t, input logic ld, input logic st, input logic sp,
                        input logic ac, input logic [7:0] h, input logic [7:0] m,
                        input logic [7:0] s);
        tick = t; load = ld; start = st; stop = sp; alarm_clr = ac;
        HCcr = h; MCcr = m; SCcr = s;
        @(posedge clk);
        #1;
        tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; alarm_clr = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s, input logic r, input logic d,
                              input logic e);
        exp_t x;
        x = '{h: h, m: m, s: s, r: r, d: d, e: e};
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic idle_cyc();
        step(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic do_tick();
        step(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic do_start();
        step(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        step(0, 1, 0, 0, 0, h, m, s);
    endtask

    initial begin
        // reset
        reset = 1'b1;
        idle_cyc();
        idle_cyc();
        expect_out("reset", 8'h00, 8'h00, 8'h00, 0, 0, 0);
        reset = 1'b0;

        // basic count 00:00:03
        do_load(8'h00, 8'h00, 8'h03); expect_out("basic_load", 8'h00, 8'h00, 8'h03, 0, 0, 0);
        do_start();                   expect_out("basic_start", 8'h00, 8'h00, 8'h03, 1, 0, 0);
        do_tick();                    expect_out("basic_t1", 8'h00, 8'h00, 8'h02, 1, 0, 0);
        do_tick();                    expect_out("basic_t2", 8'h00, 8'h00, 8'h01, 1, 0, 0);
        do_tick();                    expect_out("basic_expire", 8'h00, 8'h00, 8'h00, 0, 1, 0);
        do_tick();                    expect_out("done_tick_hold", 8'h00, 8'h00, 8'h00, 0, 1, 0);

        // alarm handling
        do_start();                   expect_out("done_start_ign", 8'h00, 8'h00, 8'h00, 0, 1, 0);
        step(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
        expect_out("alarm_clr", 8'h00, 8'h00, 8'h00, 0, 0, 0);
        do_start();                   expect_out("start_zero_ign", 8'h00, 8'h00, 8'h00, 0, 0, 0);

        // borrow chain; tick coincident with start is ignored
        do_load(8'h20, 8'h00, 8'h00); expect_out("load_20h", 8'h20, 8'h00, 8'h00, 0, 0, 0);
        step(1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
        expect_out("start_tick_ign", 8'h20, 8'h00, 8'h00, 1, 0, 0);
        do_tick();                    expect_out("borrow_20h", 8'h19, 8'h59, 8'h59, 1, 0, 0);
        step(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        expect_out("stop", 8'h19, 8'h59, 8'h59, 0, 0, 0);
        do_load(8'h01, 8'h00, 8'h00); expect_out("load_01h", 8'h01, 8'h00, 8'h00, 0, 0, 0);
        do_start();                   expect_out("start_01h", 8'h01, 8'h00, 8'h00, 1, 0, 0);
        do_tick();                    expect_out("borrow_01h", 8'h00, 8'h59, 8'h59, 1, 0, 0);
        step(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        expect_out("stop2", 8'h00, 8'h59, 8'h59, 0, 0, 0);

        // invalid presets from PAUSE
        do_load(8'h24, 8'h00, 8'h00); expect_out("bad_hr", 8'h00, 8'h59, 8'h59, 0, 0, 1);
        idle_cyc();                   expect_out("err_one_cycle", 8'h00, 8'h59, 8'h59, 0, 0, 0);
        do_load(8'h00, 8'h60, 8'h00); expect_out("bad_min", 8'h00, 8'h59, 8'h59, 0, 0, 1);
        do_load(8'h00, 8'h00, 8'h0A); expect_out("bad_sec", 8'h00, 8'h59, 8'h59, 0, 0, 1);
        do_load(8'h1A, 8'h00, 8'h00); expect_out("bad_hr_units", 8'h00, 8'h59, 8'h59, 0, 0, 1);

        // pause/resume
        do_load(8'h00, 8'h01, 8'h00); expect_out("load_1m", 8'h00, 8'h01, 8'h00, 0, 0, 0);
        do_start();                   expect_out("start_1m", 8'h00, 8'h01, 8'h00, 1, 0, 0);
        do_tick();                    expect_out("pr_t1", 8'h00, 8'h00, 8'h59, 1, 0, 0);
        do_tick();                    expect_out("pr_t2", 8'h00, 8'h00, 8'h58, 1, 0, 0);
        step(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        expect_out("tick_stop", 8'h00, 8'h00, 8'h57, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            do_tick();                expect_out("pause_hold", 8'h00, 8'h00, 8'h57, 0, 0, 0);
        end
        do_start();                   expect_out("resume", 8'h00, 8'h00, 8'h57, 1, 0, 0);
        do_tick();                    expect_out("resume_tick", 8'h00, 8'h00, 8'h56, 1, 0, 0);
        do_load(8'h00, 8'h00, 8'h10); expect_out("run_load_ign", 8'h00, 8'h00, 8'h56, 1, 0, 0);

        // load+start: load wins; then expire and reject a load alongside alarm_clr
        step(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        expect_out("stop3", 8'h00, 8'h00, 8'h56, 0, 0, 0);
        step(0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h02);
        expect_out("load_start", 8'h00, 8'h00, 8'h02, 0, 0, 0);
        do_start();                   expect_out("start_2s", 8'h00, 8'h00, 8'h02, 1, 0, 0);
        do_tick();                    expect_out("t_2s", 8'h00, 8'h00, 8'h01, 1, 0, 0);
        do_tick();                    expect_out("expire_2s", 8'h00, 8'h00, 8'h00, 0, 1, 0);
        step(0, 1, 0, 0, 1, 8'h24, 8'h00, 8'h00);
        expect_out("bad_load_clr", 8'h00, 8'h00, 8'h00, 0, 0, 1);

        // valid load while DONE clears done and returns to IDLE
        do_load(8'h00, 8'h00, 8'h01); expect_out("load_1s", 8'h00, 8'h00, 8'h01, 0, 0, 0);
        do_start();                   expect_out("start_1s", 8'h00, 8'h00, 8'h01, 1, 0, 0);
        do_tick();                    expect_out("expire_1s", 8'h00, 8'h00, 8'h00, 0, 1, 0);
        do_load(8'h23, 8'h59, 8'h59); expect_out("done_load", 8'h23, 8'h59, 8'h59, 0, 0, 0);

        // reset mid-run
        do_load(8'h12, 8'h34, 8'h56); expect_out("load_123456", 8'h12, 8'h34, 8'h56, 0, 0, 0);
        do_start();                   expect_out("start_123456", 8'h12, 8'h34, 8'h56, 1, 0, 0);
        do_tick();                    expect_out("rst_t1", 8'h12, 8'h34, 8'h55, 1, 0, 0);
        do_tick();                    expect_out("rst_t2", 8'h12, 8'h34, 8'h54, 1, 0, 0);
        reset = 1'b1;
        step(1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
        expect_out("reset_mid_run", 8'h00, 8'h00, 8'h00, 0, 0, 0);
        reset = 1'b0;
        do_start();                   expect_out("start_after_rst", 8'h00, 8'h00, 8'h00, 0, 0, 0);

        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations pending, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
